// File: rtl/latency_stats_pkg.sv
// rtl/latency_stats_pkg.sv - shared constants and saturating add for latency_stats_sink
package latency_stats_pkg;

  localparam int LAT_W_DEF = 48;
  localparam int NUM_BINS  = 16;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_SNAP_BIT = 2;

  localparam logic [7:0] SR_OFS_CTRL      = 8'd0;
  localparam logic [7:0] RB_OFS_ERR_COUNT = 8'd0;
  localparam logic [7:0] RB_OFS_MIN       = 8'd1;
  localparam logic [7:0] RB_OFS_MAX       = 8'd2;
  localparam logic [7:0] RB_OFS_SUM       = 8'd3;
  localparam logic [7:0] RB_OFS_LAST      = 8'd4;
  localparam logic [7:0] RB_OFS_EN        = 8'd5;
  localparam logic [7:0] RB_OFS_HIST      = 8'd16;

  // Adds a+b and clamps to the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s   = {1'b0, a} + {1'b0, b};
    if (s[64] || (s[63:0] > lim)) return lim;
    return s[63:0];
  endfunction

endpackage

// File: rtl/latency_stats_skid.sv
// rtl/latency_stats_skid.sv - two-entry register slice for data, tuser and tlast
// in_tready is its own flop so upstream never sees a path from out_tready.
module latency_stats_skid (
  input  logic         ce_clk,
  input  logic         ce_rst,
  input  logic [31:0]  in_tdata,
  input  logic [127:0] in_tuser,
  input  logic         in_tlast,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [31:0]  out_tdata,
  output logic [127:0] out_tuser,
  output logic         out_tlast,
  output logic         out_tvalid,
  input  logic         out_tready
);

  localparam int W = 32 + 128 + 1;

  logic [W-1:0] in_pkt;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         out_v;
  logic         skid_v;
  logic         rdy_q;
  logic         in_fire;

  assign in_pkt  = {in_tlast, in_tuser, in_tdata};
  assign in_fire = in_tvalid & rdy_q;

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (!out_v || out_tready) begin
      // Output slot frees up: the parked beat goes first, preserving order.
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else begin
        out_v <= in_fire;
        if (in_fire) out_q <= in_pkt;
      end
    end else if (in_fire) begin
      skid_q <= in_pkt;
      skid_v <= 1'b1;
      rdy_q  <= 1'b0;
    end
  end

  assign in_tready  = rdy_q;
  assign out_tvalid = out_v;
  assign {out_tlast, out_tuser, out_tdata} = out_q;

endmodule

// File: rtl/latency_stats_sink.sv
// rtl/latency_stats_sink.sv - stream pass-through with per-packet latency statistics
// Optional histogram bins are built only when LATENCY_HIST_EN is defined.
module latency_stats_sink
  import latency_stats_pkg::*;
#(
  parameter logic [7:0] SR_BASE    = 8'd130,
  parameter logic [7:0] RB_BASE    = 8'd16,
  parameter int          LAT_W      = LAT_W_DEF,
  parameter int          HIST_SHIFT = 8
) (
  input  logic         ce_clk,
  input  logic         ce_rst,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [7:0]   rb_addr,
  output logic [63:0]  rb_data,
  input  logic [31:0]  in_tdata,
  input  logic [127:0] in_tuser,
  input  logic         in_tlast,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [31:0]  out_tdata,
  output logic [127:0] out_tuser,
  output logic         out_tlast,
  output logic         out_tvalid,
  input  logic         out_tready
);

  latency_stats_skid u_skid (
    .ce_clk     (ce_clk),
    .ce_rst     (ce_rst),
    .in_tdata   (in_tdata),
    .in_tuser   (in_tuser),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tuser  (out_tuser),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  logic             ctrl_wr, clr, snap;
  logic             sop, en;
  logic             in_fire, take, good, bad;
  logic [LAT_W-1:0] lat;
  logic [31:0]      count, err;
  logic [63:0]      sum;
  logic [LAT_W-1:0] min_lat, max_lat, last;
  logic [31:0]      sh_count, sh_err;
  logic [63:0]      sh_sum;
  logic [LAT_W-1:0] sh_min, sh_max, sh_last;
  logic [63:0]      count_inc, err_inc, sum_add;
  logic [63:0]      rb_next;

  assign ctrl_wr = set_stb && (set_addr == SR_BASE + SR_OFS_CTRL);
  assign clr     = ctrl_wr & set_data[CTRL_CLR_BIT];
  assign snap    = ctrl_wr & set_data[CTRL_SNAP_BIT];
  assign in_fire = in_tvalid & in_tready;
  assign take    = in_fire & sop & en;
  assign lat     = in_tuser[LAT_W-1:0];
  // A set MSB means the upstream difference went negative or the timestamp wrapped.
  assign bad     = take & lat[LAT_W-1];
  assign good    = take & ~lat[LAT_W-1];

  assign count_inc = sat_add({32'h0, count}, 64'd1, 32);
  assign err_inc   = sat_add({32'h0, err}, 64'd1, 32);
  assign sum_add   = sat_add(sum, {{(64-LAT_W){1'b0}}, lat}, 64);

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      sop <= 1'b1;
      en  <= 1'b0;
    end else begin
      if (in_fire) sop <= in_tlast;
      if (ctrl_wr) en <= set_data[CTRL_EN_BIT];
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clr) begin
      count   <= '0;
      err     <= '0;
      sum     <= '0;
      min_lat <= '1;
      max_lat <= '0;
      last    <= '0;
    end else begin
      if (bad) err <= err_inc[31:0];
      if (good) begin
        count <= count_inc[31:0];
        sum   <= sum_add;
        last  <= lat;
        if (lat < min_lat) min_lat <= lat;
        if (lat > max_lat) max_lat <= lat;
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || (snap && clr)) begin
      sh_count <= '0;
      sh_err   <= '0;
      sh_sum   <= '0;
      sh_min   <= '1;
      sh_max   <= '0;
      sh_last  <= '0;
    end else if (snap) begin
      sh_count <= count;
      sh_err   <= err;
      sh_sum   <= sum;
      sh_min   <= min_lat;
      sh_max   <= max_lat;
      sh_last  <= last;
    end
  end

`ifdef LATENCY_HIST_EN
  logic [31:0]      bins    [NUM_BINS];
  logic [31:0]      sh_bins [NUM_BINS];
  logic [LAT_W-1:0] lat_sh;
  logic [3:0]       bin_idx;
  logic [63:0]      bin_inc;

  assign lat_sh  = lat >> HIST_SHIFT;
  assign bin_idx = (lat_sh > LAT_W'(NUM_BINS - 1)) ? 4'(NUM_BINS - 1) : lat_sh[3:0];
  assign bin_inc = sat_add({32'h0, bins[bin_idx]}, 64'd1, 32);

  always_ff @(posedge ce_clk) begin
    for (int i = 0; i < NUM_BINS; i++) begin
      if (ce_rst || clr) bins[i] <= '0;
      else if (good && (bin_idx == 4'(i))) bins[i] <= bin_inc[31:0];

      if (ce_rst || (snap && clr)) sh_bins[i] <= '0;
      else if (snap) sh_bins[i] <= bins[i];
    end
  end

  logic unused_hist;
  assign unused_hist = ^{lat_sh[LAT_W-1:4], bin_inc[63:32]};
`else
  localparam int UNUSED_HIST_CFG = HIST_SHIFT + NUM_BINS;
`endif

  always_comb begin
    rb_next = 64'h0;
    case (rb_addr)
      RB_BASE + RB_OFS_ERR_COUNT: rb_next = {sh_err, sh_count};
      RB_BASE + RB_OFS_MIN:       rb_next = {{(64-LAT_W){1'b0}}, sh_min};
      RB_BASE + RB_OFS_MAX:       rb_next = {{(64-LAT_W){1'b0}}, sh_max};
      RB_BASE + RB_OFS_SUM:       rb_next = sh_sum;
      RB_BASE + RB_OFS_LAST:      rb_next = {{(64-LAT_W){1'b0}}, sh_last};
      RB_BASE + RB_OFS_EN:        rb_next = {63'h0, en};
      default:                    rb_next = 64'h0;
    endcase
`ifdef LATENCY_HIST_EN
    for (int i = 0; i < NUM_BINS; i++)
      if (rb_addr == RB_BASE + RB_OFS_HIST + 8'(i)) rb_next = {32'h0, sh_bins[i]};
`endif
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) rb_data <= 64'h0;
    else        rb_data <= rb_next;
  end

  logic unused_bits;
  assign unused_bits = ^{set_data[31:3], count_inc[63:32], err_inc[63:32]};

endmodule
